// File: rtl/exmem_redirect_buffer.sv
// EX/MEM pipeline register that also resolves branches/jumps, drives the fetch
// redirect and squashes a configurable number of wrong-path instructions.
module exmem_redirect_buffer #(
  parameter int REG_WIDTH    = 4,
  parameter int BIT_WIDTH    = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 validIn,
  input  logic [REG_WIDTH-1:0] nextDrIn,
  input  logic [BIT_WIDTH-1:0] dFromAlu,
  input  logic [BIT_WIDTH-1:0] sr2FromAlu,
  input  logic [BIT_WIDTH-1:0] branchIn,
  input  logic [BIT_WIDTH-1:0] pcIn,
  input  logic                 memtoRegIn,
  input  logic                 memWriteIn,
  input  logic                 regWriteIn,
  input  logic                 isBranch,
  input  logic                 isJal,
  output logic                 validOut,
  output logic [REG_WIDTH-1:0] nextDrOut,
  output logic [BIT_WIDTH-1:0] aluOut,
  output logic [BIT_WIDTH-1:0] sr2Out,
  output logic [BIT_WIDTH-1:0] pcOut,
  output logic                 memtoReg,
  output logic                 memWrite,
  output logic                 regWrite,
  output logic                 redirect,
  output logic [BIT_WIDTH-1:0] redirectPc,
  output logic                 jal,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] squashCnt
);

  logic                 r_vld_p1;
  logic [REG_WIDTH-1:0] r_dr_p1;
  logic [BIT_WIDTH-1:0] r_alu_p1;
  logic [BIT_WIDTH-1:0] r_sr2_p1;
  logic [BIT_WIDTH-1:0] r_pc_p1;
  logic                 r_m2r_p1;
  logic                 r_mw_p1;
  logic                 r_rw_p1;
  logic                 r_redir_p1;
  logic [BIT_WIDTH-1:0] r_redir_pc_p1;
  logic                 r_jal_p1;
  logic [CNT_WIDTH-1:0] r_squash_cnt;

  logic w_squashing;
  logic w_take;

  // Wrong-path instructions inside the window may not start a new redirect.
  assign w_squashing = (r_squash_cnt != '0);
  assign w_take      = validIn & ~w_squashing & (isJal | (isBranch & dFromAlu[0]));

  // EX -> MEM stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_dr_p1       <= '0;
      r_alu_p1      <= '0;
      r_sr2_p1      <= '0;
      r_pc_p1       <= '0;
      r_m2r_p1      <= 1'b0;
      r_mw_p1       <= 1'b0;
      r_rw_p1       <= 1'b0;
      r_redir_p1    <= 1'b0;
      r_redir_pc_p1 <= '0;
      r_jal_p1      <= 1'b0;
      r_squash_cnt  <= '0;
    end else if (!stall) begin
      r_dr_p1  <= nextDrIn;
      r_alu_p1 <= dFromAlu;
      r_sr2_p1 <= sr2FromAlu;
      r_pc_p1  <= pcIn;
      r_m2r_p1 <= memtoRegIn;
      if (w_squashing) begin
        r_vld_p1 <= 1'b0;
        r_mw_p1  <= 1'b0;
        r_rw_p1  <= 1'b0;
      end else begin
        r_vld_p1 <= validIn;
        r_mw_p1  <= memWriteIn & validIn;
        r_rw_p1  <= regWriteIn & validIn;
      end
      if (w_take) begin
        r_redir_p1    <= 1'b1;
        r_jal_p1      <= isJal;
        r_redir_pc_p1 <= isJal ? dFromAlu : branchIn;
        r_squash_cnt  <= CNT_WIDTH'(FLUSH_CYCLES);
      end else begin
        r_redir_p1   <= 1'b0;
        r_jal_p1     <= 1'b0;
        r_squash_cnt <= w_squashing ? (r_squash_cnt - 1'b1) : '0;
      end
    end
  end

  assign validOut   = r_vld_p1;
  assign nextDrOut  = r_dr_p1;
  assign aluOut     = r_alu_p1;
  assign sr2Out     = r_sr2_p1;
  assign pcOut      = r_pc_p1;
  assign memtoReg   = r_m2r_p1;
  assign memWrite   = r_mw_p1;
  assign regWrite   = r_rw_p1;
  assign redirect   = r_redir_p1;
  assign redirectPc = r_redir_pc_p1;
  assign jal        = r_jal_p1;
  assign flush      = w_squashing;
  assign squashCnt  = r_squash_cnt;

endmodule

// File: tb/tb_exmem_redirect_buffer.sv
// Bench for exmem_redirect_buffer: two instances (FLUSH_CYCLES=1 and 2) driven in
// lockstep, checked against directed expectations and a behavioural model.
module tb_exmem_redirect_buffer;

  localparam int RW = 4;
  localparam int BW = 32;
  localparam int CW = 3;
  localparam int VW = 1 + RW + 4 * BW + 5 + 1 + 1 + CW;

  logic          clk = 1'b0;
  logic          rst, stall, validIn;
  logic [RW-1:0] nextDrIn;
  logic [BW-1:0] dFromAlu, sr2FromAlu, branchIn, pcIn;
  logic          memtoRegIn, memWriteIn, regWriteIn, isBranch, isJal;

  logic          vo [2];
  logic [RW-1:0] dr [2];
  logic [BW-1:0] alu [2], sr2 [2], pc [2], rpc [2];
  logic          m2r [2], mw [2], rw [2], rd [2], jl [2], fl [2];
  logic [CW-1:0] cnt [2];
  logic [VW-1:0] obs [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance g has FLUSH_CYCLES = g+1.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    exmem_redirect_buffer #(
      .REG_WIDTH(RW), .BIT_WIDTH(BW), .FLUSH_CYCLES(g + 1), .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .validIn(validIn),
      .nextDrIn(nextDrIn), .dFromAlu(dFromAlu), .sr2FromAlu(sr2FromAlu),
      .branchIn(branchIn), .pcIn(pcIn), .memtoRegIn(memtoRegIn),
      .memWriteIn(memWriteIn), .regWriteIn(regWriteIn), .isBranch(isBranch),
      .isJal(isJal), .validOut(vo[g]), .nextDrOut(dr[g]), .aluOut(alu[g]),
      .sr2Out(sr2[g]), .pcOut(pc[g]), .memtoReg(m2r[g]), .memWrite(mw[g]),
      .regWrite(rw[g]), .redirect(rd[g]), .redirectPc(rpc[g]), .jal(jl[g]),
      .flush(fl[g]), .squashCnt(cnt[g])
    );
    assign obs[g] = {vo[g], dr[g], alu[g], sr2[g], pc[g], m2r[g], mw[g], rw[g],
                     rd[g], rpc[g], jl[g], fl[g], cnt[g]};
  end

  // Reference model: "left" = wrong-path instructions still to be discarded.
  typedef struct {
    bit          v;
    bit [RW-1:0] dr;
    bit [BW-1:0] alu, sr2, pc, rpc;
    bit          m2r, mw, rw, rd, jl;
    int          left;
  } mdl_t;

  mdl_t m [2];

  function automatic logic [VW-1:0] expv(input mdl_t s);
    return {s.v, s.dr, s.alu, s.sr2, s.pc, s.m2r, s.mw, s.rw, s.rd, s.rpc, s.jl,
            s.left > 0, CW'(s.left)};
  endfunction

  function automatic mdl_t model_step(input mdl_t s, input int fc);
    mdl_t n;
    bit   wrong_path, resolves_taken;
    n = s;
    if (rst) begin
      n = '{default: 0};
    end else if (!stall) begin
      wrong_path     = s.left > 0;
      resolves_taken = validIn && !wrong_path && (isJal || (isBranch && dFromAlu[0]));
      n.dr  = nextDrIn;
      n.alu = dFromAlu;
      n.sr2 = sr2FromAlu;
      n.pc  = pcIn;
      n.m2r = memtoRegIn;
      n.v   = validIn && !wrong_path;
      n.mw  = n.v && memWriteIn;
      n.rw  = n.v && regWriteIn;
      n.rd  = resolves_taken;
      n.jl  = resolves_taken && isJal;
      if (resolves_taken) begin
        n.rpc  = isJal ? dFromAlu : branchIn;
        n.left = fc;
      end else begin
        n.left = wrong_path ? s.left - 1 : 0;
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = model_step(m[i], i + 1);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; validIn = 1'b0; nextDrIn = '0;
    dFromAlu = '0; sr2FromAlu = '0; branchIn = '0; pcIn = '0;
    memtoRegIn = 1'b0; memWriteIn = 1'b0; regWriteIn = 1'b0;
    isBranch = 1'b0; isJal = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; validIn = 1'b1; nextDrIn = 4'hA;
    dFromAlu = 32'h1234_5679; sr2FromAlu = 32'hDEAD_BEEF; branchIn = 32'h80;
    pcIn = 32'h44; memtoRegIn = 1'b1; memWriteIn = 1'b1; regWriteIn = 1'b1;
    isBranch = 1'b1; isJal = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs[i]);
      end
      checks++;
      if (cnt[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset_squashCnt[%0d]: got %0d want 0", i, cnt[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_taken_branch();
    validIn = 1'b1; isBranch = 1'b1; dFromAlu = 32'h1; branchIn = 32'h40;
    regWriteIn = 1'b1; nextDrIn = 4'h3;
    tick();
    checks++;
    if ({rd[1], rpc[1], jl[1], fl[1], cnt[1]} !== {1'b1, 32'h40, 1'b0, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL taken_redirect: got rd=%b pc=%h jal=%b fl=%b cnt=%0d want 1 40 0 1 2",
               rd[1], rpc[1], jl[1], fl[1], cnt[1]);
    end
    checks++;
    if ({vo[1], rw[1]} !== 2'b11) begin
      errors++;
      $display("FAIL taken_branch_kept: got v=%b rw=%b want 1 1", vo[1], rw[1]);
    end
    isBranch = 1'b0; dFromAlu = 32'h5;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({vo[1], rw[1]} !== 2'b00) begin
        errors++;
        $display("FAIL taken_squash%0d: got v=%b rw=%b want 0 0", k, vo[1], rw[1]);
      end
    end
    tick();
    checks++;
    if ({vo[1], rw[1], fl[1]} !== 3'b110) begin
      errors++;
      $display("FAIL taken_after_window: got v=%b rw=%b fl=%b want 1 1 0", vo[1], rw[1], fl[1]);
    end
    idle_inputs();
  endtask

  task automatic test_not_taken();
    validIn = 1'b1; isBranch = 1'b1; dFromAlu = 32'h2; branchIn = 32'h60;
    tick();
    checks++;
    if ({rd[1], fl[1], rd[0], fl[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL not_taken: got rd=%b fl=%b rd0=%b fl0=%b want 0 0 0 0",
               rd[1], fl[1], rd[0], fl[0]);
    end
    idle_inputs();
  endtask

  task automatic test_jal();
    validIn = 1'b1; isJal = 1'b1; isBranch = 1'b1; dFromAlu = 32'h100;
    branchIn = 32'h200; pcIn = 32'h24; regWriteIn = 1'b1;
    tick();
    checks++;
    if ({rd[1], jl[1], rpc[1], pc[1], rw[1]} !== {1'b1, 1'b1, 32'h100, 32'h24, 1'b1}) begin
      errors++;
      $display("FAIL jal: got rd=%b jal=%b rpc=%h pc=%h rw=%b want 1 1 100 24 1",
               rd[1], jl[1], rpc[1], pc[1], rw[1]);
    end
    idle_inputs();
    tick();
    checks++;
    if ({rd[1], jl[1], rpc[1]} !== {1'b0, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL jal_pulse_end: got rd=%b jal=%b rpc=%h want 0 0 100", rd[1], jl[1], rpc[1]);
    end
    tick();
    tick();
  endtask

  task automatic test_stall_window();
    validIn = 1'b1; isBranch = 1'b1; dFromAlu = 32'h1; branchIn = 32'h80;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({rd[0], fl[0], cnt[0], rpc[0]} !== {1'b1, 1'b1, 3'd1, 32'h80}) begin
        errors++;
        $display("FAIL stall_hold%0d: got rd=%b fl=%b cnt=%0d rpc=%h want 1 1 1 80",
                 k, rd[0], fl[0], cnt[0], rpc[0]);
      end
    end
    stall = 1'b0; isBranch = 1'b0; dFromAlu = 32'h9; regWriteIn = 1'b1; nextDrIn = 4'h7;
    tick();
    checks++;
    if ({vo[0], rw[0], rd[0], fl[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL stall_release_squash: got v=%b rw=%b rd=%b fl=%b want 0 0 0 0",
               vo[0], rw[0], rd[0], fl[0]);
    end
    tick();
    checks++;
    if ({vo[0], rw[0]} !== 2'b11) begin
      errors++;
      $display("FAIL stall_after_window: got v=%b rw=%b want 1 1", vo[0], rw[0]);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_window_branch_and_reset();
    validIn = 1'b1; isBranch = 1'b1; dFromAlu = 32'h1; branchIn = 32'h40;
    tick();
    branchIn = 32'h99;
    tick();
    checks++;
    if ({rd[1], cnt[1], rpc[1]} !== {1'b0, 3'd1, 32'h40}) begin
      errors++;
      $display("FAIL window_branch_ignored: got rd=%b cnt=%0d rpc=%h want 0 1 40",
               rd[1], cnt[1], rpc[1]);
    end
    tick();
    checks++;
    if (cnt[1] !== 3'd0) begin
      errors++;
      $display("FAIL window_decrement: got cnt=%0d want 0", cnt[1]);
    end
    branchIn = 32'hC0;
    tick();
    checks++;
    if ({rd[1], cnt[1]} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL window_retake: got rd=%b cnt=%0d want 1 2", rd[1], cnt[1]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({cnt[1], fl[1], rd[1]} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_window: got cnt=%0d fl=%b rd=%b want 0 0 0", cnt[1], fl[1], rd[1]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      validIn    = ($urandom_range(0, 3) != 0);
      nextDrIn   = RW'($urandom);
      dFromAlu   = $urandom;
      sr2FromAlu = $urandom;
      branchIn   = $urandom;
      pcIn       = $urandom;
      memtoRegIn = 1'($urandom);
      memWriteIn = 1'($urandom);
      regWriteIn = 1'($urandom);
      isBranch   = ($urandom_range(0, 2) == 0);
      isJal      = ($urandom_range(0, 5) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expv(m[i])) begin
          errors++;
          $display("FAIL random[%0d] cycle %0d: got %h want %h", i, n, obs[i], expv(m[i]));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    idle_inputs();
    #2;
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_jal();
    test_stall_window();
    test_window_branch_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
